// File: rtl/seg_display_capture.sv
// Recovers BCD digits from a multiplexed active-low seven-segment bus.
// A digit is committed only after its strobe and pattern stay stable for STABLE_CYCLES samples.
module seg_display_capture #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    cap_valid,
    output logic [IDX_W-1:0]        cap_index,
    output logic [3:0]              cap_value,
    output logic                    cap_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    err_sticky
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [6:0]              pat_q, pat_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    cap_valid_q, cap_valid_d;
    logic [IDX_W-1:0]        cap_index_q, cap_index_d;
    logic [3:0]              cap_value_q, cap_value_d;
    logic                    cap_err_q, cap_err_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic                    err_sticky_q, err_sticky_d;

    logic             legal;
    logic             same;
    logic             commit;
    logic [IDX_W-1:0] samp_idx;
    logic [3:0]       dec_val;
    logic             dec_err;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        legal    = $onehot(dig_q);
        samp_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q[i]) samp_idx = IDX_W'(i);
        end
        same    = (seg_q == pat_q) && (samp_idx == idx_q);
        cnt_inc = cnt_q + CNT_W'(1);
    end

    // Segment order a..g, active-low; blank is a legitimate "off" digit, not an error.
    always_comb begin
        dec_err = 1'b0;
        case (seg_q)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hE;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_W'(1);
                    pat_d   = seg_q;
                    idx_d   = samp_idx;
                end
            end
            ST_TRACK: begin
                if (!legal) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_W'(1);
                    pat_d = seg_q;
                    idx_d = samp_idx;
                end else if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                    commit  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (!legal) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_W'(1);
                    pat_d   = seg_q;
                    idx_d   = samp_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pat_d   = '0;
            idx_d   = '0;
        end
    end

    // Clear is applied last so it suppresses a coinciding commit.
    always_comb begin
        cap_valid_d   = 1'b0;
        cap_index_d   = cap_index_q;
        cap_value_d   = cap_value_q;
        cap_err_d     = cap_err_q;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        err_sticky_d  = err_sticky_q;
        if (commit) begin
            cap_valid_d  = 1'b1;
            cap_index_d  = samp_idx;
            cap_value_d  = dec_val;
            cap_err_d    = dec_err;
            err_sticky_d = err_sticky_q | dec_err;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (samp_idx == IDX_W'(i)) begin
                    digits_d[4*i +: 4] = dec_val;
                    digit_valid_d[i]   = 1'b1;
                end
            end
        end
        if (clear) begin
            cap_valid_d   = 1'b0;
            cap_index_d   = '0;
            cap_value_d   = '0;
            cap_err_d     = 1'b0;
            digits_d      = '0;
            digit_valid_d = '0;
            err_sticky_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= '0;
            dig_q         <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pat_q         <= '0;
            idx_q         <= '0;
            cap_valid_q   <= 1'b0;
            cap_index_q   <= '0;
            cap_value_q   <= '0;
            cap_err_q     <= 1'b0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            seg_q         <= seg_in;
            dig_q         <= dig_en;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            idx_q         <= idx_d;
            cap_valid_q   <= cap_valid_d;
            cap_index_q   <= cap_index_d;
            cap_value_q   <= cap_value_d;
            cap_err_q     <= cap_err_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign cap_valid   = cap_valid_q;
    assign cap_index   = cap_index_q;
    assign cap_value   = cap_value_q;
    assign cap_err     = cap_err_q;
    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Scoreboard bench for seg_display_capture: directed stimulus queues expected commits,
// a negedge monitor pops and compares each cap_valid pulse.
module tb_seg_display_capture;

    localparam int NUM_DIGITS    = 2;
    localparam int STABLE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg_in = 7'b1111111;
    logic [1:0] dig_en = 2'b00;
    logic       cap_valid;
    logic [0:0] cap_index;
    logic [3:0] cap_value;
    logic       cap_err;
    logic [7:0] digits;
    logic [1:0] digit_valid;
    logic       err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [0:0] idx;
        logic [3:0] val;
        logic       err;
    } exp_t;
    exp_t exp_q[$];

    seg_display_capture #(
        .NUM_DIGITS(NUM_DIGITS),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .seg_in(seg_in),
        .dig_en(dig_en),
        .cap_valid(cap_valid),
        .cap_index(cap_index),
        .cap_value(cap_value),
        .cap_err(cap_err),
        .digits(digits),
        .digit_valid(digit_valid),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [0:0] idx, input logic [3:0] val, input logic err);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [6:0] s, input logic [1:0] d);
        seg_in = s;
        dig_en = d;
    endtask

    // Monitor: every commit pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cap_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: got idx=%0d val=%h err=%b, expected no commit",
                         cap_index, cap_value, cap_err);
            end else begin
                e = exp_q.pop_front();
                chk("commit_index", 32'(cap_index), 32'(e.idx));
                chk("commit_value", 32'(cap_value), 32'(e.val));
                chk("commit_err",   32'(cap_err),   32'(e.err));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_cap_valid", 32'(cap_valid), 0);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_digit_valid", 32'(digit_valid), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);

        // Basic commit: 5 on digit 0, exact latency
        drive(7'b0100100, 2'b01);
        push(1'b0, 4'd5, 1'b0);
        repeat (4) @(negedge clk);
        chk("basic_no_early", 32'(cap_valid), 0);
        @(negedge clk);
        chk("basic_valid_E5", 32'(cap_valid), 1);
        chk("basic_digit0", 32'(digits[3:0]), 5);
        chk("basic_dvalid", 32'(digit_valid), 32'h1);
        repeat (5) @(negedge clk);

        // Glitch: 3 for two edges, then 7 held
        drive(7'b0000110, 2'b01);
        repeat (2) @(negedge clk);
        drive(7'b0001111, 2'b01);
        push(1'b0, 4'd7, 1'b0);
        repeat (10) @(negedge clk);
        chk("glitch_digits", 32'(digits), 32'h07);

        // Illegal strobes never commit
        drive(7'b0010010, 2'b11);
        repeat (20) @(negedge clk);
        drive(7'b0010010, 2'b00);
        repeat (20) @(negedge clk);
        chk("illegal_digits", 32'(digits), 32'h07);
        chk("illegal_dvalid", 32'(digit_valid), 32'h1);

        // Bad pattern then blank on digit 1
        drive(7'b1111110, 2'b10);
        push(1'b1, 4'hF, 1'b1);
        repeat (10) @(negedge clk);
        chk("bad_cap_err", 32'(cap_err), 1);
        chk("bad_cap_value", 32'(cap_value), 32'hF);
        chk("bad_digit1", 32'(digits[7:4]), 32'hF);
        chk("bad_sticky", 32'(err_sticky), 1);
        drive(7'b1111111, 2'b10);
        push(1'b1, 4'hE, 1'b0);
        repeat (10) @(negedge clk);
        chk("blank_value", 32'(cap_value), 32'hE);
        chk("blank_err", 32'(cap_err), 0);
        chk("blank_sticky", 32'(err_sticky), 1);

        // Mux: alternate digit0=2 / digit1=9 every 8 clocks
        for (int w = 0; w < 8; w++) begin
            if (w % 2 == 0) begin
                drive(7'b0010010, 2'b01);
                push(1'b0, 4'd2, 1'b0);
            end else begin
                drive(7'b0000100, 2'b10);
                push(1'b1, 4'd9, 1'b0);
            end
            repeat (8) @(negedge clk);
        end
        chk("mux_digits", 32'(digits), 32'h92);
        chk("mux_dvalid", 32'(digit_valid), 32'h3);

        // Clear landing on the commit edge
        drive(7'b0000000, 2'b01);
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_no_valid", 32'(cap_valid), 0);
        chk("clr_digits", 32'(digits), 0);
        chk("clr_dvalid", 32'(digit_valid), 0);
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_cap_value", 32'(cap_value), 0);
        push(1'b0, 4'd8, 1'b0);
        repeat (3) @(negedge clk);
        chk("clr_fresh_no_early", 32'(cap_valid), 0);
        @(negedge clk);
        chk("clr_fresh_valid", 32'(cap_valid), 1);
        chk("clr_fresh_digits", 32'(digits), 32'h08);
        repeat (3) @(negedge clk);

        // Async reset mid-cycle while tracking a new digit
        drive(7'b1001111, 2'b10);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cap_valid", 32'(cap_valid), 0);
        chk("arst_cap_value", 32'(cap_value), 0);
        chk("arst_digits", 32'(digits), 0);
        chk("arst_dvalid", 32'(digit_valid), 0);
        chk("arst_sticky", 32'(err_sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 4'd1, 1'b0);
        repeat (10) @(negedge clk);
        chk("post_rst_digits", 32'(digits), 32'h10);
        chk("post_rst_dvalid", 32'(digit_valid), 32'h2);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_display_capture.md
Name: seg_display_capture

Overview:
- Reverse direction of the BCD-to-seven-segment path: monitors a multiplexed, active-low seven-segment display bus and recovers the BCD digit shown in each digit position.
- Used as an on-chip self-check and readback of the parking-slot count display.
- Each digit strobe must be stable for a programmable number of clocks before its pattern is decoded and committed, so mux transitions and glitches never produce captures.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before commit (2..255).
- IDX_W (localparam), max(1, clog2(NUM_DIGITS)), width of digit index.
- CNT_W (localparam), clog2(STABLE_CYCLES+1), stability counter width.

Ports:
- clk, input, 1, system clock, all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear of captured digits, flags and FSM.
- seg_in, input, 7, segment lines, active-low, bit6=a ... bit0=g.
- dig_en, input, NUM_DIGITS, active-high digit strobes, expected one-hot.
- cap_valid, output, 1, one-cycle pulse on each commit.
- cap_index, output, IDX_W, digit position of the current commit.
- cap_value, output, 4, decoded value of the current commit.
- cap_err, output, 1, current commit was an illegal pattern (qualified by cap_valid).
- digits, output, 4*NUM_DIGITS, last committed value per position; position i occupies bits [4i+3:4i].
- digit_valid, output, NUM_DIGITS, per-position flag set on first commit.
- err_sticky, output, 1, set by any commit with cap_err, cleared by reset or clear.

Behaviour:
- Reset (rst_n low, async): all outputs 0, input registers 0, FSM in IDLE, counter 0.
- Input stage: seg_in and dig_en are registered every edge into seg_q and dig_q. The FSM uses only the registered values.
- A sample is legal when dig_q is exactly one-hot. index is the position of the set bit.
- Decode table (seg -> value):
  - 0000001 -> 0, 1001111 -> 1, 0010010 -> 2, 0000110 -> 3, 1001100 -> 4
  - 0100100 -> 5, 0100000 -> 6, 0001111 -> 7, 0000000 -> 8, 0000100 -> 9
  - 1111111 (blank) -> 4'hE, no error
  - any other pattern -> 4'hF with cap_err=1
- FSM states:
  - IDLE:
    - Legal sample -> TRACK, count=1, latch pattern and index.
    - Illegal sample -> stay in IDLE.
  - TRACK:
    - Illegal sample -> IDLE, count=0.
    - Pattern or index differs from latched -> stay in TRACK, count=1, relatch.
    - Same sample with count+1 < STABLE_CYCLES -> count+1.
    - Same sample with count+1 = STABLE_CYCLES -> commit, go to HOLD.
  - HOLD:
    - Same sample -> stay, no further commits.
    - Differing legal sample -> TRACK, count=1.
    - Illegal sample -> IDLE.
- Commit, registered on the committing edge:
  - cap_valid=1 for exactly one cycle.
  - cap_index, cap_value and cap_err are updated; they hold their value until the next commit.
  - digits[index] = value; digit_valid[index] = 1; err_sticky |= cap_err.
- Latency: seg_in/dig_en stable across STABLE_CYCLES+1 consecutive rising edges E1..E(N+1), where N = STABLE_CYCLES. cap_valid is high in the cycle after E(N+1).
- Counter never exceeds STABLE_CYCLES; there is no wrap.
- clear:
  - Resets digits, digit_valid, err_sticky and cap_* to 0, and forces the FSM to IDLE with count=0.
  - If clear and a commit coincide, clear wins: no cap_valid, no update.
- Reset mid-TRACK discards the partial count; after release, capture restarts from IDLE.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Basic commit (STABLE_CYCLES=4): dig_en=2'b01, seg_in=0100100 held from before E1 -> cap_valid high only after E5, cap_index=0, cap_value=5, digits[3:0]=5, digit_valid=2'b01.
- Glitch rejection: seg_in=0000110 (3) for 2 edges, then 0001111 (7) held 10 edges -> exactly one cap_valid, value 7, no capture of 3.
- Illegal strobe: dig_en=2'b11 or 2'b00 with a valid pattern for 20 edges -> no cap_valid, FSM stays IDLE.
- Bad pattern and blank:
  - seg_in=1111110 stable on dig_en=2'b10 -> cap_err=1, cap_value=F, digits[7:4]=F, err_sticky=1.
  - Then 1111111 stable -> cap_value=E, cap_err=0, err_sticky remains 1.
- Hold and mux: digit0=2 and digit1=9 alternating every 8 clocks for 64 clocks -> commits alternate between index 0 (value 2) and index 1 (value 9), one per strobe window, digits=8'h92.
- Clear coinciding with a commit edge -> no cap_valid, digits=0, err_sticky=0, next commit occurs only after a fresh stable window.
